// File: rtl/spdif_pkg.sv
// spdif_pkg: shared constants and types for the S/PDIF frame encoder.
// Holds the three preamble patterns, frame/block geometry, the time-slot
// positions of the V/U/C/P bits, and the stereo sample-pair record.
package spdif_pkg;

    // Preambles, first half-cell in bit 7. Each ends at line level 0.
    localparam logic [7:0] PRE_B = 8'b11101000;
    localparam logic [7:0] PRE_M = 8'b11100010;
    localparam logic [7:0] PRE_W = 8'b11100100;

    localparam int FRAMES_PER_BLOCK        = 192;
    localparam int CYCLES_PER_FRAME        = 128;
    localparam int HALF_CELLS_PER_SUBFRAME = 64;
    localparam int PREAMBLE_HALF_CELLS     = 8;

    // Time-slot numbers within a subframe.
    localparam int SLOT_FIRST_DATA = 4;
    localparam int SLOT_V          = 28;
    localparam int SLOT_U          = 29;
    localparam int SLOT_C          = 30;
    localparam int SLOT_P          = 31;

    // One stereo pair, already MSB-aligned into the 24-bit audio field.
    typedef struct packed {
        logic [23:0] left;
        logic [23:0] right;
    } sample_pair_t;

endpackage

// File: rtl/spdif_bmc_serializer.sv
// spdif_bmc_serializer: turns one subframe into 64 biphase-mark half-cells.
// Ports:
//   clk128     half-cell clock
//   reset      asynchronous, active-high
//   half_cell  index 0..63 of the half-cell being produced this cycle
//   preamble   8 preamble half-cells, bit 7 first; sampled at half_cell 0
//   slot_bits  slots 4..31 (bit 0 = slot 4); sampled at half_cell 0
//   line       registered line level (doubles as the BMC level tracker)
module spdif_bmc_serializer
    import spdif_pkg::*;
(
    input  logic        clk128,
    input  logic        reset,
    input  logic [5:0]  half_cell,
    input  logic [7:0]  preamble,
    input  logic [27:0] slot_bits,
    output logic        line
);

    logic [7:0]  pre_shift;
    logic [27:0] data_shift;

    // At half-cell 0 the inputs drive the line directly while the rest is
    // captured, so the first preamble half-cell needs no extra latency.
    // Even half-cells of a data cell always toggle; odd ones toggle for a 1.
    always_ff @(posedge clk128 or posedge reset) begin
        if (reset) begin
            line       <= 1'b0;
            pre_shift  <= '0;
            data_shift <= '0;
        end else if (half_cell == 6'd0) begin
            line       <= preamble[7];
            pre_shift  <= {preamble[6:0], 1'b0};
            data_shift <= slot_bits;
        end else if (half_cell < 6'(PREAMBLE_HALF_CELLS)) begin
            line      <= pre_shift[7];
            pre_shift <= {pre_shift[6:0], 1'b0};
        end else if (!half_cell[0]) begin
            line <= ~line;
        end else begin
            if (data_shift[0]) begin
                line <= ~line;
            end
            data_shift <= {1'b0, data_shift[27:1]};
        end
    end

endmodule

// File: rtl/spdif_frame_encoder.sv
// spdif_frame_encoder: accepts stereo PCM pairs over valid/ready and emits
// a biphase-mark S/PDIF line, one half-cell per clk128 cycle, with 192-frame
// blocks, channel status and even parity.
// Ports:
//   clk128         half-cell clock (128 x fs)
//   reset          asynchronous, active-high
//   i_left/i_right PCM samples, SAMPLE_WIDTH bits, two's complement
//   i_valid        sample pair valid
//   o_ready        one-entry holding buffer empty
//   i_cs           192-bit channel-status block, bit n sent in frame n
//   o_spdif        registered BMC line
//   o_underrun     one-cycle pulse at output cycle 0 of an underrun frame
//   o_block_start  high at output cycle 0 of frame 0
module spdif_frame_encoder
    import spdif_pkg::*;
#(
    parameter int SAMPLE_WIDTH = 24
)
(
    input  logic                    clk128,
    input  logic                    reset,
    input  logic [SAMPLE_WIDTH-1:0] i_left,
    input  logic [SAMPLE_WIDTH-1:0] i_right,
    input  logic                    i_valid,
    output logic                    o_ready,
    input  logic [191:0]            i_cs,
    output logic                    o_spdif,
    output logic                    o_underrun,
    output logic                    o_block_start
);

    logic [6:0]   cycle;
    logic [7:0]   frame;
    logic         buf_full;
    sample_pair_t hold_buf;
    sample_pair_t frame_pair;
    logic         frame_v;
    logic         frame_underrun;
    logic [191:0] cs_reg;

    logic         load_edge;
    logic         accept;
    logic [23:0]  left_aligned;
    logic [23:0]  right_aligned;
    logic         right_half;
    logic [23:0]  sample;
    logic         chan_status;
    logic [7:0]   preamble;
    logic [27:0]  slot_bits;

    assign load_edge     = (cycle == 7'(CYCLES_PER_FRAME - 1));
    assign accept        = i_valid & ~buf_full;
    assign o_ready       = ~buf_full;
    assign left_aligned  = 24'(i_left)  << (24 - SAMPLE_WIDTH);
    assign right_aligned = 24'(i_right) << (24 - SAMPLE_WIDTH);

    // Half-cell and frame counters; the 7-bit cycle counter wraps by itself.
    always_ff @(posedge clk128 or posedge reset) begin
        if (reset) begin
            cycle <= '0;
            frame <= '0;
        end else begin
            cycle <= cycle + 7'd1;
            if (load_edge) begin
                frame <= (frame == 8'(FRAMES_PER_BLOCK - 1)) ? 8'd0 : frame + 8'd1;
            end
        end
    end

    // Holding buffer. A load with a full buffer cannot coincide with an
    // acceptance because o_ready is low then, so the two cases never overlap.
    always_ff @(posedge clk128 or posedge reset) begin
        if (reset) begin
            buf_full <= 1'b0;
            hold_buf <= '0;
        end else if (accept) begin
            buf_full      <= 1'b1;
            hold_buf.left <= left_aligned;
            hold_buf.right <= right_aligned;
        end else if (load_edge) begin
            buf_full <= 1'b0;
        end
    end

    // Frame registers. Reset leaves V=1 with zero samples but no underrun
    // flag, so the first frame after reset is silent without an alarm.
    always_ff @(posedge clk128 or posedge reset) begin
        if (reset) begin
            frame_pair     <= '0;
            frame_v        <= 1'b1;
            frame_underrun <= 1'b0;
            cs_reg         <= '0;
        end else if (load_edge) begin
            if (buf_full) begin
                frame_pair     <= hold_buf;
                frame_v        <= 1'b0;
                frame_underrun <= 1'b0;
            end else begin
                frame_pair     <= '0;
                frame_v        <= 1'b1;
                frame_underrun <= 1'b1;
            end
            if (frame == 8'(FRAMES_PER_BLOCK - 1)) begin
                cs_reg <= i_cs;
            end
        end
    end

    // Status flags share the one-cycle lag of the line register.
    always_ff @(posedge clk128 or posedge reset) begin
        if (reset) begin
            o_underrun    <= 1'b0;
            o_block_start <= 1'b0;
        end else begin
            o_underrun    <= (cycle == 7'd0) && frame_underrun;
            o_block_start <= (cycle == 7'd0) && (frame == 8'd0);
        end
    end

    assign right_half  = cycle[6];
    assign sample      = right_half ? frame_pair.right : frame_pair.left;
    assign chan_status = cs_reg[frame];
    assign preamble    = right_half ? PRE_W : ((frame == 8'd0) ? PRE_B : PRE_M);

    // Parity is taken over the slots assembled so far (P still 0).
    always_comb begin
        slot_bits = '0;
        slot_bits[23:0] = sample;
        slot_bits[SLOT_V - SLOT_FIRST_DATA] = frame_v;
        slot_bits[SLOT_U - SLOT_FIRST_DATA] = 1'b0;
        slot_bits[SLOT_C - SLOT_FIRST_DATA] = chan_status;
        slot_bits[SLOT_P - SLOT_FIRST_DATA] = ^slot_bits;
    end

    spdif_bmc_serializer u_bmc (
        .clk128    (clk128),
        .reset     (reset),
        .half_cell (cycle[5:0]),
        .preamble  (preamble),
        .slot_bits (slot_bits),
        .line      (o_spdif)
    );

endmodule

// File: tb/tb_spdif_frame_encoder.sv
// Testbench for spdif_frame_encoder: drives sample pairs, decodes the BMC
// line subframe by subframe and compares against hand-derived expectations.
module tb_spdif_frame_encoder;

    logic         clk128;
    logic         reset;
    logic [23:0]  i_left;
    logic [23:0]  i_right;
    logic         i_valid;
    logic         o_ready;
    logic [191:0] i_cs;
    logic         o_spdif;
    logic         o_underrun;
    logic         o_block_start;

    spdif_frame_encoder #(.SAMPLE_WIDTH(24)) dut (
        .clk128        (clk128),
        .reset         (reset),
        .i_left        (i_left),
        .i_right       (i_right),
        .i_valid       (i_valid),
        .o_ready       (o_ready),
        .i_cs          (i_cs),
        .o_spdif       (o_spdif),
        .o_underrun    (o_underrun),
        .o_block_start (o_block_start)
    );

    initial clk128 = 1'b0;
    always #5 clk128 = ~clk128;

    typedef struct {
        logic [7:0]  pre;
        logic [27:0] bits;
        logic        bmc_ok;
        logic        end_lvl;
        logic        ur0;
        logic        ur_other;
        logic        bs0;
        logic        bs_other;
        int          ready_cnt;
        logic        ready_last;
        int          frame;
        logic        right;
        int          epoch;
    } sub_t;

    sub_t subq[$];
    int   vec_count  = 0;
    int   miss_count = 0;
    int   epoch      = 0;
    int   stim_t     = 0;
    int   pidx       = 0;
    int   pidx_rel   = 0;

    // Stimulus table: three hand-picked pairs, then a simple pattern.
    function automatic logic [47:0] pair_data(input int k);
        case (k)
            0:       pair_data = {24'h000001, 24'h800000};
            1:       pair_data = {24'h000007, 24'h000003};
            2:       pair_data = {24'hABCDEF, 24'h123456};
            default: pair_data = {8'(k), 8'hA5, ~8'(k), 8'h5A ^ 8'(k), 8'(k * 3), 8'h0F};
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vec_count++;
        if (observed !== expected) begin
            miss_count++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // One iteration per clock: a fresh pair is presented only when the
    // buffer is seen empty; otherwise junk that changes every cycle.
    // Valid is withheld across t = 448..703 of the first run.
    task automatic applyStimulus(input int cycles);
        for (int c = 0; c < cycles; c++) begin
            logic en;
            en = !(epoch == 0 && stim_t >= 448 && stim_t < 704);
            i_valid = en;
            if (en && o_ready) begin
                {i_left, i_right} = pair_data(pidx);
                pidx++;
            end else begin
                i_left  = 24'hC0FFEE ^ 24'(stim_t);
                i_right = 24'h0BADF0 + 24'(stim_t);
            end
            @(negedge clk128);
            stim_t++;
        end
    endtask

    // Line monitor: output index n counts edges since reset release.
    int   mon_n = 0;
    int   mon_h;
    logic hc [64];
    sub_t rec;

    always @(negedge clk128) begin
        if (reset) begin
            mon_n = 0;
        end else begin
            mon_h = mon_n % 64;
            hc[mon_h] = o_spdif;
            if (mon_h == 0) begin
                rec.ready_cnt = 0;
                rec.ur0       = o_underrun;
                rec.bs0       = o_block_start;
                rec.ur_other  = 1'b0;
                rec.bs_other  = 1'b0;
            end else begin
                rec.ur_other = rec.ur_other | o_underrun;
                rec.bs_other = rec.bs_other | o_block_start;
            end
            rec.ready_cnt  = rec.ready_cnt + (o_ready ? 1 : 0);
            rec.ready_last = o_ready;
            if (mon_h == 63) begin
                for (int i = 0; i < 8; i++) rec.pre[7-i] = hc[i];
                rec.bmc_ok = 1'b1;
                for (int k = 0; k < 28; k++) begin
                    if (hc[8 + 2*k] == hc[7 + 2*k]) rec.bmc_ok = 1'b0;
                    rec.bits[k] = hc[8 + 2*k] ^ hc[9 + 2*k];
                end
                rec.end_lvl = hc[63];
                rec.frame   = mon_n / 128;
                rec.right   = ((mon_n / 64) % 2) == 1;
                rec.epoch   = epoch;
                subq.push_back(rec);
            end
            mon_n++;
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    sub_t        cur;
    string       tg;
    logic [47:0] pd;
    logic [23:0] exp_sample;
    logic [7:0]  exp_pre;
    logic        exp_v, exp_c, exp_p, exp_ur0, exp_bs0, exp_rlast;
    int          exp_rcnt, f, cnt0, cnt1;
    logic        found;

    initial begin
        reset   = 1'b1;
        i_valid = 1'b0;
        i_left  = '0;
        i_right = '0;
        i_cs    = 192'h1;
        $display("[TB] start");
        repeat (3) @(negedge clk128);
        #1;
        checkOutput("rst spdif", o_spdif, 0);
        checkOutput("rst ready", o_ready, 1);
        checkOutput("rst underrun", o_underrun, 0);
        checkOutput("rst block_start", o_block_start, 0);
        reset = 1'b0;

        // 193 full frames plus the first 40 cycles of frame 193.
        applyStimulus(193 * 128 + 40);
        found = 1'b0;
        for (int w = 0; w < 16 && !found; w++) begin
            if (o_spdif) found = 1'b1;
            else applyStimulus(1);
        end
        checkOutput("pre-reset line high", found, 1);
        checkOutput("pre-reset ready low", o_ready, 0);
        #2;
        reset   = 1'b1;
        i_valid = 1'b0;
        #1;
        checkOutput("midframe rst spdif", o_spdif, 0);
        checkOutput("midframe rst ready", o_ready, 1);
        checkOutput("midframe rst underrun", o_underrun, 0);
        checkOutput("midframe rst block_start", o_block_start, 0);
        epoch = 1;
        repeat (3) @(negedge clk128);
        #1;
        reset    = 1'b0;
        pidx_rel = pidx;
        stim_t   = 0;
        applyStimulus(260);

        cnt0 = 0;
        cnt1 = 0;
        foreach (subq[i]) begin
            cur = subq[i];
            f   = cur.frame;
            if (cur.epoch == 0) cnt0++; else cnt1++;
            tg = $sformatf("e%0d f%0d %s", cur.epoch, f, cur.right ? "R" : "L");

            if (cur.right)                  exp_pre = 8'b11100100;
            else if ((f % 192) == 0)        exp_pre = 8'b11101000;
            else                            exp_pre = 8'b11100010;

            exp_v = 1'b0;
            exp_sample = '0;
            if (cur.epoch == 0) begin
                if (f == 0 || f == 5) exp_v = 1'b1;
                else if (f <= 4) pd = pair_data(f - 1);
                else             pd = pair_data(f - 2);
            end else begin
                if (f == 0) exp_v = 1'b1;
                else        pd = pair_data(pidx_rel);
            end
            if (!exp_v) exp_sample = cur.right ? pd[23:0] : pd[47:24];
            exp_c = (cur.epoch == 0) && (f == 192);
            exp_p = ^{exp_c, 1'b0, exp_v, exp_sample};

            exp_ur0 = (cur.epoch == 0) && (f == 5) && !cur.right;
            exp_bs0 = !cur.right && ((f % 192) == 0);
            if (cur.right) begin
                exp_rcnt  = (cur.epoch == 0 && f == 4) ? 64 : 1;
                exp_rlast = 1'b1;
            end else begin
                exp_rlast = (cur.epoch == 0) && (f == 4 || f == 5);
                exp_rcnt  = exp_rlast ? 64 : 0;
            end

            checkOutput({tg, " preamble"}, cur.pre, exp_pre);
            checkOutput({tg, " sample"}, cur.bits[23:0], exp_sample);
            checkOutput({tg, " V"}, cur.bits[24], exp_v);
            checkOutput({tg, " U"}, cur.bits[25], 0);
            checkOutput({tg, " C"}, cur.bits[26], exp_c);
            checkOutput({tg, " P"}, cur.bits[27], exp_p);
            checkOutput({tg, " parity even"}, ^cur.bits, 0);
            checkOutput({tg, " bmc cell edges"}, cur.bmc_ok, 1);
            checkOutput({tg, " end level"}, cur.end_lvl, 0);
            checkOutput({tg, " underrun@0"}, cur.ur0, exp_ur0);
            checkOutput({tg, " underrun other"}, cur.ur_other, 0);
            checkOutput({tg, " block_start@0"}, cur.bs0, exp_bs0);
            checkOutput({tg, " block_start other"}, cur.bs_other, 0);
            checkOutput({tg, " ready count"}, cur.ready_cnt, exp_rcnt);
            checkOutput({tg, " ready last"}, cur.ready_last, exp_rlast);

            if (cur.epoch == 0 && f == 2)
                checkOutput({tg, " P hand"}, cur.bits[27], cur.right ? 0 : 1);
            if (cur.epoch == 0 && f == 1)
                checkOutput({tg, " sample hand"}, cur.bits[23:0],
                            cur.right ? 24'h800000 : 24'h000001);
        end
        checkOutput("epoch0 subframes", cnt0, 386);
        checkOutput("epoch1 subframes", cnt1, 4);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
        $finish;
    end

endmodule

// File: doc/spdif_frame_encoder.md
# spdif_frame_encoder

Upstream transmit stage of the S/PDIF path. Takes stereo PCM samples through a valid/ready handshake and emits a biphase-mark-coded S/PDIF line at one half-cell per clk128 cycle (clk128 = 128 × fs). Each frame is 128 cycles long and contains two 64-half-cell subframes. The 192-frame block structure, channel-status bits and even parity are all generated here. The output feeds the S/PDIF line driver, and the decoder bench uses it directly.

## Interface
- SAMPLE_WIDTH, default 24: PCM width, legal range 16..24. Samples are MSB-aligned into the 24-bit slot field and unused LSBs are zero.
- clk128  in  1  half-cell clock.
- reset  in  1  reset, asynchronous, active-high.
- i_left  in  SAMPLE_WIDTH  left sample, two's complement.
- i_right  in  SAMPLE_WIDTH  right sample.
- i_valid  in  1  sample pair valid.
- o_ready  out  1  one-entry holding buffer empty.
- i_cs  in  192  channel-status block; bit n is sent in frame n.
- o_spdif  out  1  registered BMC line output.
- o_underrun  out  1  one-cycle pulse when a frame starts with the holding buffer empty.
- o_block_start  out  1  high during cycle 0 of frame 0.

## Operation
- Counters:
  - cycle 0..127, where 0..63 is the left subframe and 64..127 is the right subframe.
  - frame 0..191, which wraps to 0.
  - Half-cell index h = cycle mod 64; time slot = h/2.
- Preambles, slots 0-3, 8 half-cells:
  - B = 11101000 for left in frame 0.
  - M = 11100010 for left in other frames.
  - W = 11100100 for right.
- Slots 4-27: 24-bit sample, LSB first. Slot 4 is sample bit 0 of the MSB-aligned 24-bit value.
- Slot 28 V, slot 29 U = 0, slot 30 C = cs_reg[frame] (same in both subframes), slot 31 P.
- P makes slots 4-31 contain an even number of ones.
- BMC for slots 4-31:
  - Invert the line at the start of every bit cell.
  - Invert again at mid-cell if the bit is 1.
- Because parity is even, the line is always 0 at the end of each subframe, so the preambles above are always emitted in non-inverted form.
- Handshake:
  - A sample pair is accepted when i_valid & o_ready at a rising edge; it is written into the holding buffer.
  - o_ready = buffer empty.
- Load edge: the rising edge that ends cycle 127.
  - Buffer full: move the buffer into the frame registers, set V=0, empty the buffer.
  - Buffer empty: frame samples = 0, V=1, and o_underrun pulses.
- An acceptance on the load edge itself fills the buffer for the following frame. The frame starting at that edge transmits as underrun.
- cs_reg is loaded from i_cs on the load edge that enters frame 0.

## Timing
- Reset values:
  - o_spdif = 0, o_underrun = 0, o_block_start = 0, o_ready = 1.
  - cycle = 0, frame = 0, buffer empty, cs_reg = 0, frame samples = 0.
- Asserting reset mid-frame forces these values immediately, since reset is asynchronous.
- First edge after reset release: o_spdif = 1, the first half-cell of B in frame 0.
- That first frame sends zero samples with V=1 and C=0. No o_underrun pulse is raised for it.
- o_spdif is valid one register stage after the counter state. The preamble occupies the first 8 output cycles of each subframe.
- o_ready:
  - Falls on the edge after acceptance.
  - Rises on the load edge that consumes the buffer.
- Latency: a pair accepted at or before the edge ending cycle 126 is transmitted in the next frame.
- o_underrun and o_block_start are registered, aligned to output cycle 0.

## Structure
- Package spdif_pkg holds:
  - Preamble constants PRE_B/PRE_M/PRE_W.
  - FRAMES_PER_BLOCK = 192, CYCLES_PER_FRAME = 128, HALF_CELLS_PER_SUBFRAME = 64.
  - Slot indices for V/U/C/P.
- Sub-module spdif_bmc_serializer:
  - Inputs: 8-bit preamble plus 28 slot bits, loaded at h = 0.
  - Emits 64 half-cells and tracks line level.
  - Parity is computed in the top level.

## Test plan
- Continuous valid with L = 24'h000001, R = 24'h800000: frame 0 left begins 11101000, right begins 11100100, frame 1 left begins 11100010. Decoded result is Sample 000001 / 800000, V=0, no parity error.
- Drop i_valid for one frame: o_underrun pulses once at cycle 0. That frame decodes Sample 00000 with V=1 and correct parity. The next valid pair resumes normally.
- i_cs = 192'h1, 193 frames: C=1 only in frames 0 of both subframes. After frame 191, B reappears and o_block_start pulses.
- L = 24'h000007, C=0: P=1. L = 24'h000003: P=0. o_spdif = 0 at every subframe end.
- Hold i_valid with changing data while o_ready = 0: no pair is lost or duplicated, and o_ready rises exactly on each load edge.
- Assert reset at cycle 40: o_spdif = 0 immediately. After release, the line restarts with B, V=1, and no o_underrun.
